// File: rtl/tdot_pkg.sv
// Shared constants and slice helpers for the tdot issue controller.
// Lane-major packing: term t of lane l sits at (l*TERMS+t)*W.
package tdot_pkg;

  localparam int LANES   = 5;
  localparam int TERMS   = 3;
  localparam int W       = 8;
  localparam int LAT     = TERMS + 2;
  localparam int MUL_LAT = 2;
  localparam int AW      = LANES * TERMS * W;
  localparam int CW      = LANES * W;
  localparam int RW      = 16;

  function automatic int ab_lo(input int l, input int t);
    return (l * TERMS + t) * W;
  endfunction

  function automatic int c_lo(input int l);
    return l * W;
  endfunction

endpackage

// File: rtl/tdot_sched_if.sv
// Bundle between tdot_sched and its producer, consumer and datapath.
// slave = scheduler side, master = environment side.
interface tdot_sched_if;
  import tdot_pkg::*;

  logic          clr;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_a;
  logic [AW-1:0] in_b;
  logic [CW-1:0] in_c;
  logic          dp_en;
  logic [AW-1:0] dp_a;
  logic [AW-1:0] dp_b;
  logic [CW-1:0] dp_c;
  logic [CW-1:0] dp_res;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_res;
  logic          busy;
  logic [RW-1:0] retired;

  modport slave (
    input  clr, in_valid, in_a, in_b, in_c,
    input  dp_res, out_ready,
    output in_ready, dp_en, dp_a, dp_b, dp_c,
    output out_valid, out_res, busy, retired
  );

  modport master (
    output clr, in_valid, in_a, in_b, in_c,
    output dp_res, out_ready,
    input  in_ready, dp_en, dp_a, dp_b, dp_c,
    input  out_valid, out_res, busy, retired
  );

endinterface

// File: rtl/tdot_skew_line.sv
// Enabled delay line of DEPTH registers with synchronous clear.
// Ports: clk_i, rst_i, clr_i, en_i (shift), d_i in, q_o delayed out.
module tdot_skew_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] pipe_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else if (en_i) begin
      pipe_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/tdot_sched.sv
// Issue controller for the 5-lane x 3-term dot-product datapath.
// Ports: clock, reset, bus (skewed issue, dp enable, result handshake).
module tdot_sched
  import tdot_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  tdot_sched_if.slave  bus
);

  logic          adv;
  logic          acc;
  logic [AW-1:0] a_g;
  logic [AW-1:0] b_g;
  logic [CW-1:0] c_g;
  logic [AW-1:0] dp_a_w;
  logic [AW-1:0] dp_b_w;
  logic [CW-1:0] dp_c_w;
  logic [LAT-1:0] vsr_q, vsr_d;
  logic [RW-1:0]  retired_q, retired_d;

  // The only stall source is a result the consumer refuses.
  assign adv = !(vsr_q[LAT-1] && !bus.out_ready);
  assign acc = bus.in_valid && adv;

  // Bubbles enter as zeros so the datapath never recycles stale operands.
  assign a_g = acc ? bus.in_a : '0;
  assign b_g = acc ? bus.in_b : '0;
  assign c_g = acc ? bus.in_c : '0;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    for (genvar t = 0; t < TERMS; t++) begin : g_term
      if (t == 0) begin : g_pass
        assign dp_a_w[ab_lo(l, t) +: W] = a_g[ab_lo(l, t) +: W];
        assign dp_b_w[ab_lo(l, t) +: W] = b_g[ab_lo(l, t) +: W];
      end else begin : g_skew
        tdot_skew_line #(.WIDTH(W), .DEPTH(t)) u_a (
          .clk_i (clock),
          .rst_i (reset),
          .clr_i (bus.clr),
          .en_i  (adv),
          .d_i   (a_g[ab_lo(l, t) +: W]),
          .q_o   (dp_a_w[ab_lo(l, t) +: W])
        );
        tdot_skew_line #(.WIDTH(W), .DEPTH(t)) u_b (
          .clk_i (clock),
          .rst_i (reset),
          .clr_i (bus.clr),
          .en_i  (adv),
          .d_i   (b_g[ab_lo(l, t) +: W]),
          .q_o   (dp_b_w[ab_lo(l, t) +: W])
        );
      end
    end

    // Addend meets the term-0 product after the multiplier registers.
    tdot_skew_line #(.WIDTH(W), .DEPTH(MUL_LAT)) u_c (
      .clk_i (clock),
      .rst_i (reset),
      .clr_i (bus.clr),
      .en_i  (adv),
      .d_i   (c_g[c_lo(l) +: W]),
      .q_o   (dp_c_w[c_lo(l) +: W])
    );
  end

  always_comb begin
    vsr_d     = vsr_q;
    retired_d = retired_q;
    if (vsr_q[LAT-1] && bus.out_ready) retired_d = retired_q + 1'b1;
    if (bus.clr) vsr_d = '0;
    else if (adv) vsr_d = {vsr_q[LAT-2:0], acc};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vsr_q     <= '0;
      retired_q <= '0;
    end else begin
      vsr_q     <= vsr_d;
      retired_q <= retired_d;
    end
  end

  assign bus.dp_en     = adv;
  assign bus.in_ready  = adv;
  assign bus.dp_a      = dp_a_w;
  assign bus.dp_b      = dp_b_w;
  assign bus.dp_c      = dp_c_w;
  assign bus.out_valid = vsr_q[LAT-1];
  assign bus.out_res   = bus.dp_res;
  assign bus.busy      = |vsr_q;
  assign bus.retired   = retired_q;

endmodule

// File: tb/tb_tdot_sched.sv
// Bench for tdot_sched: stand-in datapath, queue model, directed tests.
// Prints one CHECKS/ERRORS summary line.
module tb_tdot_sched;
  import tdot_pkg::*;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic rst_p = 1'b0;

  tdot_sched_if bus();

  tdot_sched u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    rst_p = reset;
    cyc   = cyc + 1;
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // Stand-in datapath: 2-stage multipliers, addend joins term 0,
  // then terms 1 and 2 are chained, result registered.
  logic signed [W-1:0] m1 [TERMS][LANES];
  logic signed [W-1:0] m2 [TERMS][LANES];
  logic signed [W-1:0] s0 [LANES];
  logic signed [W-1:0] s1 [LANES];
  logic signed [W-1:0] rs [LANES];

  always @(posedge clock) begin
    if (reset) begin
      for (int l = 0; l < LANES; l++) begin
        for (int t = 0; t < TERMS; t++) begin
          m1[t][l] <= '0;
          m2[t][l] <= '0;
        end
        s0[l] <= '0;
        s1[l] <= '0;
        rs[l] <= '0;
      end
    end else if (bus.dp_en) begin
      for (int l = 0; l < LANES; l++) begin
        for (int t = 0; t < TERMS; t++) begin
          m1[t][l] <= $signed(bus.dp_a[ab_lo(l, t) +: W])
                    * $signed(bus.dp_b[ab_lo(l, t) +: W]);
          m2[t][l] <= m1[t][l];
        end
        s0[l] <= m2[0][l] + $signed(bus.dp_c[c_lo(l) +: W]);
        s1[l] <= s0[l] + m2[1][l];
        rs[l] <= s1[l] + m2[2][l];
      end
    end
  end

  always_comb begin
    bus.dp_res = '0;
    for (int l = 0; l < LANES; l++) bus.dp_res[c_lo(l) +: W] = rs[l];
  end

  // Reference dot product: plain integer sums, wrapped to W bits.
  function automatic logic [CW-1:0] dot(input logic [AW-1:0] a,
                                        input logic [AW-1:0] b,
                                        input logic [CW-1:0] c);
    logic [CW-1:0] r;
    int s;
    r = '0;
    for (int l = 0; l < LANES; l++) begin
      s = int'($signed(c[c_lo(l) +: W]));
      for (int t = 0; t < TERMS; t++)
        s += int'($signed(a[ab_lo(l, t) +: W]))
           * int'($signed(b[ab_lo(l, t) +: W]));
      r[c_lo(l) +: W] = s[W-1:0];
    end
    return r;
  endfunction

  // Model: each accepted set needs LAT advancing edges to reach the output.
  typedef struct {
    logic [CW-1:0] res;
    int            age;
  } ent_t;
  ent_t mq[$];
  int   exp_ret = 0;

  always @(negedge clock) begin : cmp
    logic ev;
    logic am;
    ev = (mq.size() > 0) && (mq[0].age == LAT);
    am = !(ev && !bus.out_ready);
    if (rst_p) begin
      chk("rst_valid", bus.out_valid, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_ret", bus.retired, 0);
      chk("rst_rdy", bus.in_ready, 1);
      chk("rst_en", bus.dp_en, 1);
      if (!bus.in_valid) begin
        chk("rst_dpa", |bus.dp_a, 0);
        chk("rst_dpb", |bus.dp_b, 0);
        chk("rst_dpc", |bus.dp_c, 0);
      end
    end else begin
      chk("valid", bus.out_valid, ev);
      if (ev) chk("res", bus.out_res, mq[0].res);
      chk("in_ready", bus.in_ready, am);
      chk("dp_en", bus.dp_en, am);
      chk("busy", bus.busy, mq.size() > 0);
      chk("retired", bus.retired, exp_ret);
    end
    if (reset) begin
      mq.delete();
      exp_ret = 0;
    end else begin
      if (ev && bus.out_ready) begin
        void'(mq.pop_front());
        exp_ret = (exp_ret + 1) & 32'hFFFF;
      end
      if (bus.clr) mq.delete();
      else if (am) begin
        for (int i = 0; i < mq.size(); i++) mq[i].age = mq[i].age + 1;
        if (bus.in_valid)
          mq.push_back('{res: dot(bus.in_a, bus.in_b, bus.in_c), age: 1});
      end
    end
  end

  // Delivered results with the cycle they were taken.
  logic [CW-1:0] got[$];
  int            gcyc[$];

  always @(negedge clock) begin
    if (!rst_p && bus.out_valid && bus.out_ready) begin
      got.push_back(bus.out_res);
      gcyc.push_back(cyc);
    end
  end

  function automatic logic [CW-1:0] gv(input int i);
    return (i < got.size()) ? got[i] : '1;
  endfunction

  function automatic int gc(input int i);
    return (i < gcyc.size()) ? gcyc[i] : -1;
  endfunction

  logic [AW-1:0] va, vb;
  logic [CW-1:0] vc;
  int            t0;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clr_vec();
    va = '0;
    vb = '0;
    vc = '0;
  endtask

  task automatic put(input int l, input int a0, input int a1, input int a2,
                     input int b0, input int b1, input int b2, input int c);
    va[ab_lo(l, 0) +: W] = a0[W-1:0];
    va[ab_lo(l, 1) +: W] = a1[W-1:0];
    va[ab_lo(l, 2) +: W] = a2[W-1:0];
    vb[ab_lo(l, 0) +: W] = b0[W-1:0];
    vb[ab_lo(l, 1) +: W] = b1[W-1:0];
    vb[ab_lo(l, 2) +: W] = b2[W-1:0];
    vc[c_lo(l) +: W]     = c[W-1:0];
  endtask

  task automatic drive();
    bus.in_a     = va;
    bus.in_b     = vb;
    bus.in_c     = vc;
    bus.in_valid = 1'b1;
  endtask

  task automatic lane0_set(input int v);
    clr_vec();
    put(0, v, 0, 0, 1, 0, 0, 0);
    drive();
  endtask

  task automatic flush_got();
    got.delete();
    gcyc.delete();
  endtask

  initial begin
    reset         = 1'b1;
    bus.clr       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_c      = '0;
    repeat (3) step();
    reset = 1'b0;
    step();

    // Single set, lane0 = 4+10+18+7 = 39
    clr_vec();
    put(0, 1, 2, 3, 4, 5, 6, 7);
    chk("pin_t1", dot(va, vb, vc), 40'h27);
    flush_got();
    t0 = cyc;
    drive();
    step();
    bus.in_valid = 1'b0;
    repeat (6) step();
    chk("t1_cnt", got.size(), 1);
    chk("t1_res", gv(0), 40'h00_00_00_00_27);
    chk("t1_lat", gc(0) - t0, LAT);
    chk("t1_ret", bus.retired, 1);

    // Wrap: lane2 600 -> 0x58, lane4 -1*1 + -1 -> 0xFE
    clr_vec();
    put(2, 100, 100, 100, 2, 2, 2, 0);
    put(4, -1, 0, 0, 1, 0, 0, -1);
    chk("pin_t2", dot(va, vb, vc), 40'hFE_00_58_00_00);
    flush_got();
    t0 = cyc;
    drive();
    step();
    bus.in_valid = 1'b0;
    repeat (6) step();
    chk("t2_cnt", got.size(), 1);
    chk("t2_res", gv(0), 40'hFE_00_58_00_00);
    chk("t2_lat", gc(0) - t0, LAT);

    // Streaming 8 sets back to back
    flush_got();
    t0 = cyc;
    for (int i = 1; i <= 8; i++) begin
      lane0_set(i);
      #1;
      chk("t3_rdy", bus.in_ready, 1);
      step();
    end
    bus.in_valid = 1'b0;
    repeat (8) step();
    chk("t3_cnt", got.size(), 8);
    for (int j = 0; j < 8; j++) begin
      chk("t3_res", gv(j), 40'(j + 1));
      chk("t3_cyc", gc(j), t0 + LAT + j);
    end

    // Backpressure: hold the first result for 4 cycles
    flush_got();
    t0 = cyc;
    for (int i = 0; i < 3; i++) begin
      lane0_set(11 + i);
      step();
    end
    bus.in_valid = 1'b0;
    repeat (2) step();
    bus.out_ready = 1'b0;
    for (int s = 0; s < 4; s++) begin
      #1;
      chk("t4_valid", bus.out_valid, 1);
      chk("t4_en", bus.dp_en, 0);
      chk("t4_rdy", bus.in_ready, 0);
      chk("t4_hold", bus.out_res, 40'h0B);
      step();
    end
    bus.out_ready = 1'b1;
    repeat (6) step();
    chk("t4_cnt", got.size(), 3);
    for (int j = 0; j < 3; j++) begin
      chk("t4_res", gv(j), 40'(11 + j));
      chk("t4_cyc", gc(j), t0 + 9 + j);
    end
    chk("t4_ret", bus.retired, 13);

    // clr two cycles after the second set
    flush_got();
    lane0_set(21);
    step();
    lane0_set(22);
    step();
    bus.in_valid = 1'b0;
    step();
    bus.clr = 1'b1;
    step();
    bus.clr = 1'b0;
    #1;
    chk("t5_busy", bus.busy, 0);
    chk("t5_valid", bus.out_valid, 0);
    repeat (8) step();
    chk("t5_cnt", got.size(), 0);
    chk("t5_ret", bus.retired, 13);
    clr_vec();
    put(0, 3, 0, 0, 5, 0, 0, 1);
    t0 = cyc;
    drive();
    step();
    bus.in_valid = 1'b0;
    repeat (6) step();
    chk("t5_cnt2", got.size(), 1);
    chk("t5_res", gv(0), 40'h10);
    chk("t5_lat", gc(0) - t0, LAT);
    chk("t5_ret2", bus.retired, 14);

    // Reset with 3 sets in flight and the output stalled
    flush_got();
    for (int i = 0; i < 3; i++) begin
      lane0_set(31 + i);
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) step();
    chk("t6_stall", bus.out_valid, 1);
    reset = 1'b1;
    step();
    chk("t6_valid", bus.out_valid, 0);
    chk("t6_busy", bus.busy, 0);
    chk("t6_ret", bus.retired, 0);
    chk("t6_rdy", bus.in_ready, 1);
    reset         = 1'b0;
    bus.out_ready = 1'b1;
    repeat (10) step();
    chk("t6_cnt", got.size(), 0);
    chk("t6_ret2", bus.retired, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
